// File: rtl/kbd_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : kbd_scancode_decoder
// Purpose  : Turns the PS/2 set-2 byte stream from a serial receiver into
//            completed key events. It tracks the E0 (extended) and F0 (break)
//            prefixes, drops keyboard control/response bytes, and aborts a
//            half-received prefix sequence after TIMEOUT_CYCLES idle clocks.
// Ports    : clk        - system clock, all logic on the rising edge
//            reset      - synchronous, active-high
//            din[7:0]   - received byte, valid only while din_new is high
//            din_new    - one-cycle strobe marking a new byte
//            keyCode[8:0] - last completed code {extended, scan code}
//            make       - one-cycle pulse, key in keyCode pressed
//            brakee     - one-cycle pulse, key in keyCode released
//            seq_error  - one-cycle pulse, prefix sequence timed out
// Config   : KBD_PAUSE_SEQ_EN - when defined, E1 in IDLE reports the Pause
//            key (keyCode 9'h1E1) and the following 7 bytes are discarded.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       seq_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] c_to_last = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] c_cnt_max = '1;

`ifdef KBD_PAUSE_SEQ_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;
  logic [2:0] r_skip;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3
  } state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_ctrl;
  logic          w_timeout;

  // Keyboard control/response bytes: never part of a key code.
  always_comb begin
    w_ctrl = 1'b0;
    case (din)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: w_ctrl = 1'b1;
      default: w_ctrl = 1'b0;
    endcase
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state != S_IDLE) && !din_new && (r_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      keyCode   <= 9'h000;
      make      <= 1'b0;
      brakee    <= 1'b0;
      seq_error <= 1'b0;
`ifdef KBD_PAUSE_SEQ_EN
      r_skip    <= 3'd0;
`endif
    end else begin
      make      <= 1'b0;
      brakee    <= 1'b0;
      seq_error <= 1'b0;

      // Idle-gap counter: only runs while a sequence is in progress and
      // sticks at its maximum rather than wrapping.
      if (din_new || (r_state == S_IDLE))
        r_cnt <= '0;
      else if (r_cnt != c_cnt_max)
        r_cnt <= r_cnt + CW'(1);

      if (din_new) begin
        case (r_state)
          S_IDLE: begin
            if (din == 8'hE0)
              r_state <= S_EXT;
            else if (din == 8'hF0)
              r_state <= S_BRK;
            else if (w_ctrl)
              r_state <= S_IDLE;
`ifdef KBD_PAUSE_SEQ_EN
            else if (din == 8'hE1) begin
              make    <= 1'b1;
              keyCode <= 9'h1E1;
              r_skip  <= 3'd0;
              r_state <= S_SKIP;
            end
`endif
            else begin
              make    <= 1'b1;
              keyCode <= {1'b0, din};
            end
          end
          S_EXT: begin
            if (din == 8'hF0)
              r_state <= S_EXT_BRK;
            else if (din == 8'hE0)
              r_state <= S_EXT;
            else if (w_ctrl)
              r_state <= S_IDLE;
            else begin
              make    <= 1'b1;
              keyCode <= {1'b1, din};
              r_state <= S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            if (din == 8'hF0)
              r_state <= r_state;
            else if (din == 8'hE0)
              r_state <= S_EXT;        // new sequence starts over
            else if (w_ctrl)
              r_state <= S_IDLE;
            else begin
              brakee  <= 1'b1;
              keyCode <= {(r_state == S_EXT_BRK), din};
              r_state <= S_IDLE;
            end
          end
`ifdef KBD_PAUSE_SEQ_EN
          S_SKIP: begin
            // Seven trailing Pause bytes: counter values 0..6.
            if (r_skip == 3'd6)
              r_state <= S_IDLE;
            else
              r_skip <= r_skip + 3'd1;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state   <= S_IDLE;
        seq_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_scancode_decoder
// Purpose  : Directed bench for kbd_scancode_decoder. Each stimulus sequence
//            pushes its expected event into a queue; a monitor pops and
//            compares whenever make/brakee/seq_error is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_scancode_decoder;

  localparam int TO = 16;
  localparam logic [1:0] K_MAKE = 2'd0;
  localparam logic [1:0] K_BRK  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_new;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;
  logic       seq_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];   // {kind, keyCode}
  logic [8:0]  exp_kc;     // last completed code, tracked by the bench
  logic [8:0]  prev_kc;
  logic        rst_d;

  kbd_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_new  (din_new),
    .keyCode  (keyCode),
    .make     (make),
    .brakee   (brakee),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    din     = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
    din     = 8'h00;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [8:0] kc);
    if (kind != K_ERR) exp_kc = kc;
    exp_q.push_back({kind, exp_kc});
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) rst_d <= reset;

  // Monitor: compares every presented event against the queue head and
  // watches the output invariants.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!reset && !rst_d) begin
      check("make_brakee_exclusive", {31'd0, make & brakee}, 32'd0);
      if (make || brakee || seq_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {29'd0, make, brakee, seq_error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {29'd0, make, brakee, seq_error},
                (e[10:9] == K_MAKE) ? 32'd4 : (e[10:9] == K_BRK) ? 32'd2 : 32'd1);
          check("event_keyCode", {23'd0, keyCode}, {23'd0, e[8:0]});
        end
      end else if (keyCode !== prev_kc) begin
        check("keyCode_hold", {23'd0, keyCode}, {23'd0, prev_kc});
      end
    end
    prev_kc <= keyCode;
  end

  initial begin
    reset = 1'b1; din = 8'h00; din_new = 1'b0; exp_kc = 9'h000;
    gap(3);
    check("reset_keyCode", {23'd0, keyCode}, 32'h000);
    check("reset_make", {31'd0, make}, 32'd0);
    check("reset_brakee", {31'd0, brakee}, 32'd0);
    check("reset_seq_error", {31'd0, seq_error}, 32'd0);
    reset = 1'b0;
    gap(2);

    // Plain make, then keyCode must hold.
    expect_ev(K_MAKE, 9'h01C); send(8'h1C);
    check("make_latency", {31'd0, make}, 32'd1);
    gap(3);
    check("keyCode_held", {23'd0, keyCode}, 32'h01C);

    // Break, extended break, extended make.
    send(8'hF0); expect_ev(K_BRK, 9'h01C); send(8'h1C); gap(2);
    send(8'hE0); send(8'hF0); expect_ev(K_BRK, 9'h175); send(8'h75); gap(2);
    send(8'hE0); expect_ev(K_MAKE, 9'h175); send(8'h75); gap(2);

    // Repeated prefixes and restart of a break by E0.
    send(8'hE0); send(8'hE0); expect_ev(K_MAKE, 9'h16B); send(8'h6B); gap(2);
    send(8'hF0); send(8'hF0); expect_ev(K_BRK, 9'h012); send(8'h12); gap(2);
    send(8'hF0); send(8'hE0); expect_ev(K_MAKE, 9'h174); send(8'h74); gap(2);
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'hF0);
    expect_ev(K_BRK, 9'h174); send(8'h74); gap(2);

    // Control bytes: silent in IDLE, and they abort a prefix.
    send(8'hAA); send(8'hFA); gap(2);
    check("ctrl_keyCode_unchanged", {23'd0, keyCode}, 32'h174);
    send(8'hE0); send(8'hAA); expect_ev(K_MAKE, 9'h01C); send(8'h1C); gap(2);
    send(8'hF0); send(8'hFE); expect_ev(K_MAKE, 9'h021); send(8'h21); gap(2);

    // Back-to-back codes, each with its own pulse.
    expect_ev(K_MAKE, 9'h01C); send(8'h1C);
    expect_ev(K_MAKE, 9'h032); send(8'h32);
    send(8'hF0); expect_ev(K_BRK, 9'h032); send(8'h32);
    expect_ev(K_MAKE, 9'h021); send(8'h21); gap(2);

    // Timeout after E0: no error one cycle early, error exactly at TO.
    expect_ev(K_ERR, 9'h000); send(8'hE0);
    gap(TO - 1);
    check("no_early_timeout", {31'd0, seq_error}, 32'd0);
    gap(1);
    check("timeout_pulse", {31'd0, seq_error}, 32'd1);
    expect_ev(K_MAKE, 9'h029); send(8'h29); gap(2);

    // Timeout after F0, then byte must be a make.
    expect_ev(K_ERR, 9'h000); send(8'hF0); gap(TO + 2);
    expect_ev(K_MAKE, 9'h005); send(8'h05); gap(2);

    // Byte arriving in the expiry cycle wins over the timeout.
    send(8'hE0); gap(TO - 1);
    expect_ev(K_MAKE, 9'h175); send(8'h75); gap(TO + 2);

    // Reset mid-sequence dominates a simultaneous byte.
    send(8'hF0);
    reset = 1'b1; din = 8'h1C; din_new = 1'b1;
    @(negedge clk);
    reset = 1'b0; din_new = 1'b0; din = 8'h00; exp_kc = 9'h000;
    check("midseq_reset_keyCode", {23'd0, keyCode}, 32'h000);
    check("midseq_reset_brakee", {31'd0, brakee}, 32'd0);
    gap(2);
    expect_ev(K_MAKE, 9'h01C); send(8'h1C); gap(2);

`ifdef KBD_PAUSE_SEQ_EN
    expect_ev(K_MAKE, 9'h1E1); send(8'hE1);
    send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
    send(8'h14); send(8'hF0); send(8'h77); gap(2);
    expect_ev(K_MAKE, 9'h01C); send(8'h1C); gap(2);
    expect_ev(K_MAKE, 9'h1E1); send(8'hE1);
    expect_ev(K_ERR, 9'h000); send(8'h14); gap(TO + 2);
    expect_ev(K_MAKE, 9'h029); send(8'h29); gap(2);
`else
    expect_ev(K_MAKE, 9'h0E1); send(8'hE1);
    expect_ev(K_MAKE, 9'h014); send(8'h14); gap(2);
`endif

    gap(TO + 4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
